// File: rtl/int_arith_pkg.sv
// Shared integer-arithmetic definitions for the multiplier and divider.
// Holds the FSM state encoding, default width and counter sizing helper.
package int_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;

  // Bits needed to hold an iteration count of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/int_abs.sv
// Signed-to-magnitude converter: value (signed) -> mag (unsigned), sign.
// Most-negative input maps to 2^(WIDTH-1), which still fits in mag.
import int_arith_pkg::*;

module int_abs #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = value[WIDTH-1];
  assign mag  = sign ? -value : value;

endmodule

// File: rtl/int_mul.sv
// Radix-2 shift-add signed multiplier, WIDTH x WIDTH -> 2*WIDTH product.
// Ports: clk, rst_n, multiplicand, multiplier, calc -> product, busy,
// calc_done_stb (+ overflow when INT_MUL_OVERFLOW_EN is defined).
import int_arith_pkg::*;

module int_mul #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               calc,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               calc_done_stb
`ifdef INT_MUL_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t            state, state_n;
  logic [WIDTH-1:0]  mag_a, mag_a_n;
  logic [WIDTH-1:0]  mag_b, mag_b_n;
  logic [PW-1:0]     acc, acc_n;
  logic [CW-1:0]     count, count_n;
  logic              sign, sign_n;
  logic [PW-1:0]     product_n;
  logic              busy_n;
  logic              done_n;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic              sa, sb;
  logic              zero_op;
  logic [WIDTH:0]    addend;
  logic [WIDTH:0]    sum;
  logic [PW-1:0]     res;

  int_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value (multiplicand),
    .mag   (abs_a),
    .sign  (sa)
  );

  int_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value (multiplier),
    .mag   (abs_b),
    .sign  (sb)
  );

  assign zero_op = (multiplicand == '0)
                 | (multiplier == '0);

  // Carry lands in sum[WIDTH] and is shifted back into acc's top bit.
  assign addend = mag_b[0] ? {1'b0, mag_a} : '0;
  assign sum    = {1'b0, acc[PW-1:WIDTH]} + addend;
  assign res    = sign ? -acc : acc;

`ifdef INT_MUL_OVERFLOW_EN
  logic ovf_n;
  logic res_fits;

  // Fits in WIDTH-bit signed iff the top WIDTH+1 bits are all equal.
  assign res_fits = (&res[PW-1:WIDTH-1])
                  | ~(|res[PW-1:WIDTH-1]);
`endif

  always_comb begin
    state_n   = state;
    mag_a_n   = mag_a;
    mag_b_n   = mag_b;
    acc_n     = acc;
    count_n   = count;
    sign_n    = sign;
    product_n = product;
    busy_n    = busy;
    done_n    = 1'b0;
`ifdef INT_MUL_OVERFLOW_EN
    ovf_n     = overflow;
`endif
    unique case (state)
      IDLE: begin
        if (calc) begin
          if (zero_op) begin
            product_n = '0;
            done_n    = 1'b1;
`ifdef INT_MUL_OVERFLOW_EN
            ovf_n     = 1'b0;
`endif
          end else begin
            mag_a_n = abs_a;
            mag_b_n = abs_b;
            sign_n  = sa ^ sb;
            acc_n   = '0;
            count_n = CW'(WIDTH);
            busy_n  = 1'b1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        acc_n   = {sum, acc[WIDTH-1:1]};
        mag_b_n = mag_b >> 1;
        count_n = count - CW'(1);
        if (count == CW'(1)) begin
          state_n = FIX;
        end
      end
      FIX: begin
        product_n = res;
        done_n    = 1'b1;
        busy_n    = 1'b0;
`ifdef INT_MUL_OVERFLOW_EN
        ovf_n     = ~res_fits;
`endif
        state_n   = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mag_a         <= '0;
      mag_b         <= '0;
      acc           <= '0;
      count         <= '0;
      sign          <= 1'b0;
      product       <= '0;
      busy          <= 1'b0;
      calc_done_stb <= 1'b0;
`ifdef INT_MUL_OVERFLOW_EN
      overflow      <= 1'b0;
`endif
    end else begin
      state         <= state_n;
      mag_a         <= mag_a_n;
      mag_b         <= mag_b_n;
      acc           <= acc_n;
      count         <= count_n;
      sign          <= sign_n;
      product       <= product_n;
      busy          <= busy_n;
      calc_done_stb <= done_n;
`ifdef INT_MUL_OVERFLOW_EN
      overflow      <= ovf_n;
`endif
    end
  end

endmodule
